// File: rtl/addern_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addern_seq_pkg
// Description : Shared types for the addern_seq wide-addition sequencer:
//               the sequencer state encoding and its width.
//               Optional feature macro used by the bundle: ADDERN_SEQ_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package addern_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/addern_seq_addern.sv
`default_nettype none
// ============================================================================
// Module      : Addern
// Description : N-bit ripple-style slice adder with carry in and carry out.
//               This is the datapath slice reused by addern_seq over several
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module Addern #(
  parameter int N = 4
) (
  input  logic         Cin,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic [N-1:0] S,
  output logic         Cout
);

  // Full slice sum; the extra MSB is the carry out.
  assign {Cout, S} = {1'b0, X} + {1'b0, Y} + {{N{1'b0}}, Cin};

endmodule
`default_nettype wire

// File: rtl/addern_seq.sv
`default_nettype none
// ============================================================================
// Module      : addern_seq
// Description : Multi-cycle wide adder. Adds two N*K-bit operands by running
//               one N-bit Addern slice over K consecutive cycles, carrying
//               between slices through a register. Start/Busy/Done handshake
//               with a registered result that holds until the next operation.
//               Define ADDERN_SEQ_OVF_EN to add the signed-overflow output Ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module addern_seq
  import addern_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Cin,
  input  logic [N*K-1:0] A,
  input  logic [N*K-1:0] B,
  output logic           Busy,
  output logic           Done,
  output logic [N*K-1:0] Sum,
  output logic           Cout
`ifdef ADDERN_SEQ_OVF_EN
  ,
  output logic           Ovf
`endif
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            c_q, c_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [N-1:0]    slice_s;
  logic            slice_co;
  logic [W-1:0]    acc_next;

`ifdef ADDERN_SEQ_OVF_EN
  // Operand MSBs are kept separately because a_q/b_q shift away during RUN.
  logic            amsb_q, amsb_d;
  logic            bmsb_q, bmsb_d;
  logic            ovf_q, ovf_d;
`endif

  Addern #(
    .N (N)
  ) u_slice (
    .Cin  (c_q),
    .X    (a_q[N-1:0]),
    .Y    (b_q[N-1:0]),
    .S    (slice_s),
    .Cout (slice_co)
  );

  // Newest slice enters at the top so after K shifts slice 0 sits at the bottom.
  assign acc_next = {slice_s, acc_q[W-1:N]};

  // Next-state and datapath control for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDERN_SEQ_OVF_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          acc_d   = '0;
          idx_d   = '0;
`ifdef ADDERN_SEQ_OVF_EN
          amsb_d  = A[W-1];
          bmsb_d  = B[W-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_next;
        a_d   = a_q >> N;
        b_d   = b_q >> N;
        c_d   = slice_co;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(K - 1)) begin
          sum_d   = acc_next;
          cout_d  = slice_co;
`ifdef ADDERN_SEQ_OVF_EN
          ovf_d   = (amsb_q == bmsb_q) && (acc_next[W-1] != amsb_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift-register and result registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDERN_SEQ_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDERN_SEQ_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef ADDERN_SEQ_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addern_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_addern_seq
// Description : Self-checking bench for addern_seq (N=4, K=4). A cycle-level
//               reference model derived from acceptance times and plain
//               integer addition is compared with the DUT every cycle;
//               directed cases pin literal results. Honours ADDERN_SEQ_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addern_seq;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         Cin   = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
`ifdef ADDERN_SEQ_OVF_EN
  logic         Ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  addern_seq #(
    .N (N),
    .K (K)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Cin   (Cin),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout)
`ifdef ADDERN_SEQ_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An operation accepted at edge number acc_e is busy for edges acc_e..acc_e+K,
  // shows Done after edge acc_e+K, and frees the block for acceptance at acc_e+K+2.
  int           e      = 0;
  int           acc_e  = 0;
  bit           active = 1'b0;
  logic [W:0]   pend   = '0;
  logic         pend_ovf = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;

  initial begin
    forever begin
      @(posedge Clock);
      e++;
      if (Reset) begin
        active = 1'b0;
        m_sum  = '0;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
      end else begin
        if (active && (e - acc_e == K)) begin
          m_sum  = pend[W-1:0];
          m_cout = pend[W];
          m_ovf  = pend_ovf;
        end
        if (Start && (!active || (e - acc_e >= K + 2))) begin
          active   = 1'b1;
          acc_e    = e;
          pend     = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
          pend_ovf = (A[W-1] == B[W-1]) && (pend[W-1] != A[W-1]);
        end
      end
      @(negedge Clock);
      begin
        int  d;
        bit  x_busy;
        bit  x_done;
        d      = e - acc_e;
        x_busy = active && (d >= 0) && (d <= K);
        x_done = active && (d == K);
        chk("busy", 32'(Busy), 32'(x_busy));
        chk("done", 32'(Done), 32'(x_done));
        chk("sum",  32'(Sum),  32'(m_sum));
        chk("cout", 32'(Cout), 32'(m_cout));
`ifdef ADDERN_SEQ_OVF_EN
        chk("ovf",  32'(Ovf),  32'(m_ovf));
`endif
      end
    end
  end

  // One Start pulse, then wait (bounded) for Done; lat counts cycles after acceptance.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat);
    @(negedge Clock); #1;
    Start = 1'b1; A = a; B = b; Cin = c;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock); #1;
      Start = 1'b0;
      if (Done) begin
        lat = k;
        break;
      end
    end
    chk("done_seen", 32'(lat >= 0), 32'd1);
  endtask

  initial begin
    int lat;
    int dones;
    int last;

    repeat (2) @(negedge Clock);
    #1 Reset = 1'b0;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_sum",  32'(Sum),  32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);

    // Basic add
    run_op(16'h1234, 16'h0FFF, 1'b0, lat);
    chk("t1_lat",  32'(lat),  32'd4);
    chk("t1_sum",  32'(Sum),  32'h2233);
    chk("t1_cout", 32'(Cout), 32'd0);

    // Start while busy, with operands changed mid-operation
    @(negedge Clock); #1;
    Start = 1'b1; A = 16'h1234; B = 16'h0FFF; Cin = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clock); #1;
      if (k == 0) Start = 1'b0;
      if (k == 1) begin
        Start = 1'b1; A = 16'h1111; B = 16'h1111;
      end
      if (k == 3) Start = 1'b0;
      if (Done) dones++;
    end
    chk("t3_dones", 32'(dones), 32'd1);
    chk("t3_sum",   32'(Sum),   32'h2233);

    // Reset on the second RUN cycle
    @(negedge Clock); #1;
    Start = 1'b1; A = 16'h5555; B = 16'hAAAA; Cin = 1'b1;
    @(negedge Clock); #1;
    Start = 1'b0;
    @(negedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock); #1;
    Reset = 1'b0;
    chk("t4_busy", 32'(Busy), 32'd0);
    chk("t4_done", 32'(Done), 32'd0);
    chk("t4_sum",  32'(Sum),  32'd0);
    chk("t4_cout", 32'(Cout), 32'd0);
    repeat (8) begin
      @(negedge Clock); #1;
      chk("t4_nopub", 32'(Done), 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, lat);
    chk("t4_sum2", 32'(Sum), 32'h0002);

    // Full carry ripple
    run_op(16'hFFFF, 16'h0000, 1'b1, lat);
    chk("t2_sum",  32'(Sum),  32'h0000);
    chk("t2_cout", 32'(Cout), 32'd1);

`ifdef ADDERN_SEQ_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    chk("t5a_sum",  32'(Sum),  32'h8000);
    chk("t5a_ovf",  32'(Ovf),  32'd1);
    chk("t5a_cout", 32'(Cout), 32'd0);
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("t5b_sum",  32'(Sum),  32'h0000);
    chk("t5b_ovf",  32'(Ovf),  32'd0);
    chk("t5b_cout", 32'(Cout), 32'd1);
`endif

    // Back-to-back with Start held for 20 edges
    @(negedge Clock); #1;
    Start = 1'b1; A = 16'h0010; B = 16'h0020; Cin = 1'b0;
    dones = 0;
    last  = -1;
    for (int k = 0; k < 28; k++) begin
      @(negedge Clock); #1;
      if (k == 19) Start = 1'b0;
      if (Done) begin
        dones++;
        chk("t6_sum", 32'(Sum), 32'h0030);
        if (last >= 0) chk("t6_gap", 32'(k - last), 32'd6);
        last = k;
      end
    end
    chk("t6_dones", 32'(dones), 32'd4);

    // Randomized traffic with occasional resets
    repeat (1500) begin
      @(negedge Clock); #1;
      Start = ($urandom_range(0, 2) == 0);
      A     = W'($urandom);
      B     = W'($urandom);
      Cin   = 1'($urandom_range(0, 1));
      Reset = ($urandom_range(0, 149) == 0);
    end
    @(negedge Clock); #1;
    Reset = 1'b0;
    Start = 1'b0;
    repeat (10) @(negedge Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/addern_seq.md
# addern_seq

Multi-cycle wide-addition sequencer that drives one N-bit `Addern` slice over K consecutive cycles to add two N·K-bit operands. Carry is registered between slices. The block sits between board-level controls (switches/pushbuttons, or any requester) and the existing `Addern` datapath, and reuses that adder instead of building a wide one. It has a single start/busy/done handshake and a registered result that holds until the next accepted operation.

## Interface
- `N`, default 4: width of the `Addern` slice.
- `K`, default 4: number of slices; K ≥ 2. Total operand width is N·K.
- `Clock`  in  1  single system clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request a new addition; accepted only in IDLE.
- `Cin`  in  1  carry-in to slice 0; sampled with `Start`.
- `A`  in  N·K  operand A; sampled with `Start`.
- `B`  in  N·K  operand B; sampled with `Start`.
- `Busy`  out  1  high in RUN and DONE.
- `Done`  out  1  one-cycle pulse; `Sum`/`Cout` are valid from this cycle onward.
- `Sum`  out  N·K  registered result.
- `Cout`  out  1  registered carry out of the top slice.
- `Ovf`  out  1  signed overflow; present only when `ADDERN_SEQ_OVF_EN` is defined.

## Operation
- States:
  - IDLE: `Start`=1 latches `A`, `B` and `Cin` into the shift registers `a_q`, `b_q` and `c_q`, clears slice counter `idx`, and moves to RUN. `Start`=0 stays in IDLE.
  - RUN: `Addern` adds `a_q[N-1:0]`, `b_q[N-1:0]` and `c_q`.
    - Each cycle: the slice sum shifts into the top of accumulator `acc_q`, `a_q`/`b_q` shift right by N, `c_q` takes the slice carry-out, and `idx` increments.
    - When `idx`=K-1, the final `acc_q` value (including this cycle's slice) loads into `Sum`, the carry loads into `Cout`, and the state moves to DONE.
  - DONE: `Done`=1 for exactly this cycle; next state IDLE unconditionally.
- `Start` in RUN or DONE is ignored; there is no queueing. Operands are taken only from the accepting edge, so changing `A`/`B` mid-operation has no effect.
- `Sum`, `Cout` and `Ovf` change only on the edge that enters DONE, or on reset. Otherwise they hold.
- Arithmetic: unsigned modulo 2^(N·K), so `Sum` = (A + B + Cin) mod 2^(N·K) and `Cout` = bit N·K of the full sum.
- `idx` width is $clog2(K).
- Reset values: state IDLE, `Busy`=0, `Done`=0, `Sum`=0, `Cout`=0, `Ovf`=0, and all internal registers 0.
- Reset in any state, including mid-RUN, aborts the operation on that edge. No partial result is published.

## Timing
- Let edge e0 be the edge that accepts `Start`. Slice i is registered at edge e(i+1). `Sum`/`Cout` become valid and `Done`=1 in the cycle after edge eK.
- Latency from the accepting edge to `Done` visible: K cycles.
- The earliest next acceptance is edge e(K+2), so the minimum period is K+2 cycles.
- With `Start` held high continuously, `Done` pulses every K+2 cycles.
- `Busy` rises in the cycle after e0 and falls in the cycle after e(K+1).

## Configuration
- `ADDERN_SEQ_OVF_EN` defined: the `Ovf` port exists.
  - On the DONE-entry edge it registers (A_msb == B_msb) && (Sum_msb != A_msb), using the MSBs of the latched operands and of the final sum.
  - `Ovf` holds between operations and resets to 0.
- Undefined: the `Ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `addern_seq_pkg` holds:
  - the state enum `{IDLE, RUN, DONE}`;
  - a localparam for the state width.
- Sub-module: exactly one instance of the existing `Addern`, with ports in this order: carry-in, X, Y, S, carry-out. It is instantiated with width N.
- All sequencing, shift registers and result registers live in `addern_seq` itself.

## Test plan
1. Basic add: N=4, K=4, A=16'h1234, B=16'h0FFF, Cin=0, one-cycle `Start` → `Done` pulses 4 cycles after acceptance, `Sum`=16'h2233, `Cout`=0.
2. Full carry ripple: A=16'hFFFF, B=16'h0000, Cin=1 → `Sum`=16'h0000, `Cout`=1.
3. Start while busy: a second `Start` with A=16'h1111, B=16'h1111 during RUN → ignored; the result of test 1 is unchanged and exactly one `Done` pulse occurs.
4. Reset mid-RUN: assert `Reset` on the second RUN cycle → next cycle `Busy`=0, `Done`=0, `Sum`=0, `Cout`=0. A following op with A=16'h0001, B=16'h0001 → `Sum`=16'h0002.
5. Overflow (macro defined):
   - A=16'h7FFF, B=16'h0001 → `Sum`=16'h8000, `Ovf`=1, `Cout`=0.
   - A=16'hFFFF, B=16'h0001 → `Sum`=0, `Ovf`=0, `Cout`=1.
6. Back-to-back: `Start` held high for 20 cycles with A=16'h0010, B=16'h0020 → `Done` pulses every 6 cycles, and every result is `Sum`=16'h0030.
